// File: rtl/wb_mem_responder.sv
// Wishbone memory responder: clears its word store after reset, then serves
// single reads/writes with a fixed LATENCY. Define WB_MEM_RESPONDER_ERR_EN for err_o range checking.
module wb_mem_responder #(
    parameter int WORD_SIZE  = 256,
    parameter int DEPTH_BITS = 6,
    parameter int ADDR_LSB   = 7,
    parameter int LATENCY    = 3
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    output logic                 initialized,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 ack_o
`ifdef WB_MEM_RESPONDER_ERR_EN
    ,
    output logic                 err_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, ACK} state_t;

    state_t                state;
    state_t                next_state;
    logic [DEPTH_BITS-1:0] clear_idx;
    logic [3:0]            lat_cnt;
    logic [3:0]            next_lat_cnt;
    logic                  accept;
    logic                  complete;

    logic                  cap_we;
    logic                  cap_err;
    logic [DEPTH_BITS-1:0] cap_idx;
    logic [WORD_SIZE-1:0]  cap_data;

    logic [DEPTH_BITS-1:0] live_idx;
    logic                  live_err;
    logic                  addr_unused;

    logic                  txn_we;
    logic                  txn_err;
    logic [DEPTH_BITS-1:0] txn_idx;
    logic [WORD_SIZE-1:0]  txn_data;

    logic                  mem_we;
    logic [DEPTH_BITS-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic [WORD_SIZE-1:0]  mem [DEPTH];

    assign live_idx    = addr_i[ADDR_LSB +: DEPTH_BITS];
    assign addr_unused = ^addr_i;

`ifdef WB_MEM_RESPONDER_ERR_EN
    assign live_err = |(addr_i >> (ADDR_LSB + DEPTH_BITS));
`else
    assign live_err = 1'b0;
`endif

    // With LATENCY=1 the transaction completes on its acceptance edge, so the
    // live bus values must be used instead of the not-yet-captured copies.
    assign txn_we   = (state == IDLE) ? we_i     : cap_we;
    assign txn_err  = (state == IDLE) ? live_err : cap_err;
    assign txn_idx  = (state == IDLE) ? live_idx : cap_idx;
    assign txn_data = (state == IDLE) ? data_i   : cap_data;

    always_comb begin
        next_state   = state;
        next_lat_cnt = lat_cnt;
        accept       = 1'b0;
        complete     = 1'b0;
        case (state)
            CLEAR: begin
                if (&clear_idx) next_state = IDLE;
            end
            IDLE: begin
                if (cyc_i && stb_i) begin
                    accept = 1'b1;
                    if (LAT == 4'd1) begin
                        complete     = 1'b1;
                        next_state   = ACK;
                        next_lat_cnt = 4'd0;
                    end else begin
                        next_state   = WAIT;
                        next_lat_cnt = LAT;
                    end
                end
            end
            WAIT: begin
                if (!cyc_i) begin
                    next_state   = IDLE;
                    next_lat_cnt = 4'd0;
                end else if (lat_cnt == 4'd1) begin
                    complete     = 1'b1;
                    next_state   = ACK;
                    next_lat_cnt = 4'd0;
                end else begin
                    next_lat_cnt = lat_cnt - 4'd1;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clear_idx   <= '0;
            initialized <= 1'b0;
            lat_cnt     <= 4'd0;
        end else begin
            state   <= next_state;
            lat_cnt <= next_lat_cnt;
            if (state == CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
                if (&clear_idx) initialized <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we   <= 1'b0;
            cap_err  <= 1'b0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else if (accept) begin
            cap_we   <= we_i;
            cap_err  <= live_err;
            cap_idx  <= live_idx;
            cap_data <= data_i;
        end
    end

    // Out-of-range requests complete with err_o and touch neither memory nor data_o.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o  <= 1'b0;
            data_o <= '0;
`ifdef WB_MEM_RESPONDER_ERR_EN
            err_o  <= 1'b0;
`endif
        end else begin
            ack_o <= complete && !txn_err;
`ifdef WB_MEM_RESPONDER_ERR_EN
            err_o <= complete && txn_err;
`endif
            if (complete && !txn_we && !txn_err) data_o <= mem[txn_idx];
        end
    end

    assign mem_we    = (state == CLEAR) || (complete && txn_we && !txn_err);
    assign mem_addr  = (state == CLEAR) ? clear_idx : txn_idx;
    assign mem_wdata = (state == CLEAR) ? '0 : txn_data;

    always_ff @(posedge sys_clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

endmodule
